// File: rtl/disp_pkg.sv
// disp_pkg
// Shared constants and helpers for the seven-segment scan controller.
//   NUM_DIGITS / NIBBLE_W / DIGIT_IDX_W : display geometry
//   DATA_W                              : packed display value width
//   digit_idx_t                         : digit select type
//   lz_blank_mask()                     : leading-zero blank mask of a value
package disp_pkg;

    localparam int NUM_DIGITS  = 8;
    localparam int NIBBLE_W    = 4;
    localparam int DIGIT_IDX_W = 3;
    localparam int DATA_W      = NUM_DIGITS * NIBBLE_W;

    typedef logic [DIGIT_IDX_W-1:0] digit_idx_t;

    // Bit i is set when nibbles NUM_DIGITS-1 down to i are all zero.
    // Digit 0 always shows, so a value of zero still displays "0".
    function automatic logic [NUM_DIGITS-1:0] lz_blank_mask(input logic [DATA_W-1:0] value);
        logic [NUM_DIGITS-1:0] mask;
        logic                  above_zero;
        mask       = '0;
        above_zero = 1'b1;
        for (int i = NUM_DIGITS - 1; i >= 1; i--) begin
            above_zero = above_zero & (value[i*NIBBLE_W +: NIBBLE_W] == '0);
            mask[i]    = above_zero;
        end
        return mask;
    endfunction

endpackage

// File: rtl/disp_scan_ctrl_if.sv
// disp_scan_ctrl_if
// Valid/ready load port carrying a new display value into the scan controller.
//   load_valid : source offers load_data
//   load_data  : 32-bit display value, nibble i = bits [4i+3:4i]
//   load_ready : sink pending buffer is empty
// Modports: master = value source, slave = scan controller.
interface disp_scan_ctrl_if;
    import disp_pkg::*;

    logic              load_valid;
    logic [DATA_W-1:0] load_data;
    logic              load_ready;

    modport master (
        output load_valid,
        output load_data,
        input  load_ready
    );

    modport slave (
        input  load_valid,
        input  load_data,
        output load_ready
    );

endinterface

// File: rtl/disp_prescaler.sv
// disp_prescaler
// Refresh prescaler: counts 0..PRESCALE-1 while enabled, held at 0 otherwise.
//   clk, rst_n : clock, asynchronous active-low reset
//   en         : count enable; low forces the count to 0
//   slot_end   : combinational, high in the last cycle of a digit slot
//   dead_next  : combinational, the count after this edge lies in the dead time
module disp_prescaler #(
    parameter int PRESCALE = 50000,
    parameter int DEAD     = 16,
    parameter int CNT_W    = $clog2(PRESCALE)
) (
    input  logic clk,
    input  logic rst_n,
    input  logic en,
    output logic slot_end,
    output logic dead_next
);

    localparam logic [CNT_W-1:0] LAST = CNT_W'(PRESCALE - 1);

    logic [CNT_W-1:0] cnt_reg;
    logic [CNT_W-1:0] cnt_next;

    always_comb begin
        cnt_next = cnt_reg;
        if (!en) begin
            cnt_next = '0;
        end else if (cnt_reg == LAST) begin
            cnt_next = '0;
        end else begin
            cnt_next = cnt_reg + CNT_W'(1);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_reg <= '0;
        end else begin
            cnt_reg <= cnt_next;
        end
    end

    assign slot_end = en && (cnt_reg == LAST);

    // The anode register is loaded from next-state values, so the dead-time
    // flag looks at the count that will be current after the edge.
    generate
        if (DEAD == 0) begin : g_no_dead
            assign dead_next = 1'b0;
        end else begin : g_dead
            localparam logic [CNT_W-1:0] DEAD_C = CNT_W'(DEAD);
            assign dead_next = (cnt_next < DEAD_C);
        end
    endgenerate

endmodule

// File: rtl/disp_scan_ctrl.sv
// disp_scan_ctrl
// Refresh/scan controller for an 8-digit seven-segment display feeding an
// 8:1 nibble mux. A new value is taken through a one-entry pending buffer and
// copied into the frame-stable shadow register at a frame boundary (or at once
// while the display is disabled).
//   clk, rst_n : clock, asynchronous active-low reset
//   enable     : scan enable; low = display dark, scan held at digit 0
//   load       : valid/ready load port (slave side)
//   blank_lz   : leading-zero blanking enable
//   digits     : shadow register, drives the mux data inputs
//   sel        : current digit index, drives the mux select
//   anode_n    : active-low digit enables, one-hot-low or all ones
//   digit_tick : one-cycle pulse when sel advances
//   frame_tick : one-cycle pulse when sel wraps 7 -> 0
module disp_scan_ctrl
    import disp_pkg::*;
#(
    parameter int PRESCALE = 50000,
    parameter int DEAD     = 16,
    parameter int CNT_W    = $clog2(PRESCALE)
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  enable,
    disp_scan_ctrl_if.slave       load,
    input  logic                  blank_lz,
    output logic [DATA_W-1:0]     digits,
    output digit_idx_t            sel,
    output logic [NUM_DIGITS-1:0] anode_n,
    output logic                  digit_tick,
    output logic                  frame_tick
);

    generate
        if (PRESCALE < 2 || DEAD < 0 || DEAD >= PRESCALE) begin : g_bad_params
            $error("disp_scan_ctrl: need PRESCALE >= 2 and 0 <= DEAD < PRESCALE");
        end
    endgenerate

    localparam digit_idx_t LAST_DIGIT = DIGIT_IDX_W'(NUM_DIGITS - 1);

    logic slot_end;
    logic dead_next;

    disp_prescaler #(
        .PRESCALE (PRESCALE),
        .DEAD     (DEAD),
        .CNT_W    (CNT_W)
    ) u_prescaler (
        .clk       (clk),
        .rst_n     (rst_n),
        .en        (enable),
        .slot_end  (slot_end),
        .dead_next (dead_next)
    );

    digit_idx_t            sel_reg, sel_next;
    logic [DATA_W-1:0]     digits_reg, digits_next;
    logic [DATA_W-1:0]     pend_reg, pend_next;
    logic                  pend_full_reg, pend_full_next;
    logic [NUM_DIGITS-1:0] anode_reg, anode_next;
    logic                  digit_tick_reg, digit_tick_next;
    logic                  frame_tick_reg, frame_tick_next;
    logic                  frame_end;
    logic                  xfer;
    logic                  accept;
    logic [NUM_DIGITS-1:0] blank_mask;

    assign frame_end = slot_end && (sel_reg == LAST_DIGIT);

    // A transfer needs a buffer that was already full before this edge and a
    // capture needs an empty one, so they can never chain within one cycle.
    assign xfer   = pend_full_reg && (!enable || frame_end);
    assign accept = load.load_valid && !pend_full_reg;

    always_comb begin
        digits_next    = digits_reg;
        pend_next      = pend_reg;
        pend_full_next = pend_full_reg;
        if (xfer) begin
            digits_next    = pend_reg;
            pend_full_next = 1'b0;
        end else if (accept) begin
            pend_next      = load.load_data;
            pend_full_next = 1'b1;
        end
    end

    always_comb begin
        sel_next = sel_reg;
        if (!enable) begin
            sel_next = '0;
        end else if (slot_end) begin
            sel_next = sel_reg + DIGIT_IDX_W'(1);
        end
    end

    assign digit_tick_next = slot_end;
    assign frame_tick_next = frame_end;

    // Blanking follows the value that will be on the mux after this edge so
    // a freshly transferred value is blanked correctly from its first slot.
    assign blank_mask = blank_lz ? lz_blank_mask(digits_next) : '0;

    generate
        for (genvar gi = 0; gi < NUM_DIGITS; gi++) begin : g_anode
            assign anode_next[gi] = ~(enable && !dead_next && !blank_mask[gi] &&
                                      (sel_next == DIGIT_IDX_W'(gi)));
        end
    endgenerate

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sel_reg        <= '0;
            digits_reg     <= '0;
            pend_reg       <= '0;
            pend_full_reg  <= 1'b0;
            anode_reg      <= '1;
            digit_tick_reg <= 1'b0;
            frame_tick_reg <= 1'b0;
        end else begin
            sel_reg        <= sel_next;
            digits_reg     <= digits_next;
            pend_reg       <= pend_next;
            pend_full_reg  <= pend_full_next;
            anode_reg      <= anode_next;
            digit_tick_reg <= digit_tick_next;
            frame_tick_reg <= frame_tick_next;
        end
    end

    assign load.load_ready = !pend_full_reg;
    assign digits          = digits_reg;
    assign sel             = sel_reg;
    assign anode_n         = anode_reg;
    assign digit_tick      = digit_tick_reg;
    assign frame_tick      = frame_tick_reg;

endmodule
